debug_unlock_ctrl: RTL and testbench
====================================

DEBUG_UNLOCK_CTRL -- requirements
Module: debug_unlock_ctrl

Interface
REQ-001 SHALL have parameter KEY0, default 16'hA5C3, first unlock key word.
REQ-002 SHALL have parameter KEY1, default 16'h3C5A, second unlock key word.
REQ-003 SHALL have parameter SESSION_CYC, default 1024, unlocked-session length in cycles (>=2).
REQ-004 SHALL have parameter PENALTY_CYC, default 16, post-failure dead time in cycles (>=1).
REQ-005 SHALL have parameter MAX_FAIL, default 3, failed attempts before permanent lockout (1..3).
REQ-006 Clk  input  1  rising-edge clock.
REQ-007 resetn  input  1  asynchronous, active-low reset.
REQ-008 key_valid  input  1  key word offered.
REQ-009 key_data  input  16  key word.
REQ-010 key_ready  output  1  controller accepts a key word this cycle.
REQ-011 relock  input  1  request to end session or abort a sequence.
REQ-012 debug_unlocked  output  1  debug write-override grant to the downstream lock-protected data register.
REQ-013 lockout  output  1  permanent lockout indicator.
REQ-014 fail_count  output  2  failed attempts since reset or last successful unlock.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_K1, UNLOCKED, PENALTY, LOCKOUT.
REQ-016 Accept SHALL be key_valid & key_ready; key_ready SHALL be 1 only in IDLE and WAIT_K1, driven combinationally from state.
REQ-017 IDLE: accept with key_data==KEY0 -> WAIT_K1; accept with mismatch -> failure handling.
REQ-018 WAIT_K1: accept with key_data==KEY1 -> UNLOCKED, fail_count cleared to 0, session counter loaded SESSION_CYC-1; mismatch -> failure handling.
REQ-019 WAIT_K1: relock high -> IDLE, no fail counted; relock has priority over a same-cycle accept.
REQ-020 Failure handling: fail_count increments by 1, saturating at MAX_FAIL; if new value == MAX_FAIL -> LOCKOUT, else -> PENALTY with penalty counter loaded PENALTY_CYC-1.
REQ-021 PENALTY: penalty counter decrements each cycle; at 0 -> IDLE; key_valid and relock ignored.
REQ-022 UNLOCKED: session counter decrements each cycle; relock high or counter==0 -> IDLE; key inputs ignored.
REQ-023 debug_unlocked SHALL be a registered output, 1 exactly while state==UNLOCKED: first high the cycle after the KEY1 accept edge, low the cycle after the exit edge.
REQ-024 Session length without relock SHALL be exactly SESSION_CYC cycles of debug_unlocked high.
REQ-025 LOCKOUT: terminal until resetn; key_ready=0, debug_unlocked=0, lockout=1; relock ignored.
REQ-026 relock in IDLE, PENALTY, LOCKOUT SHALL have no effect.
REQ-027 Counters SHALL not wrap; session and penalty counters sized for their parameters, fail_count 2 bits.
REQ-028 No combinational path from key_data to debug_unlocked.

Reset
REQ-029 resetn low SHALL asynchronously force state=IDLE, debug_unlocked=0, lockout=0, fail_count=0, both counters=0.
REQ-030 Reset asserted mid-session or mid-sequence SHALL drop debug_unlocked in the same reset assertion, with no partial key progress retained.
REQ-031 After resetn deasserts, key_ready SHALL be 1 from the first clock edge.

Verification
REQ-032 After reset, key words A5C3 then 3C5A accepted on consecutive cycles -> debug_unlocked rises the cycle after the second accept and stays high 1024 cycles, then 0; fail_count=0.
REQ-033 Unlocked, relock pulsed at cycle 10 of the session -> debug_unlocked 0 next cycle; state IDLE; key_ready 1.
REQ-034 Word 1234 in IDLE -> fail_count=1, key_ready 0 for 16 cycles, key_valid ignored meanwhile, then key_ready 1.
REQ-035 Three wrong attempts (A5C3/0000, 1111, A5C3/FFFF) -> lockout=1, fail_count=3; a subsequent correct A5C3/3C5A does not assert debug_unlocked; only resetn clears lockout.
REQ-036 A5C3 accepted, then relock and key_valid with 3C5A in the same cycle -> IDLE, debug_unlocked stays 0, fail_count unchanged.
REQ-037 resetn asserted while debug_unlocked=1 between clock edges -> debug_unlocked 0 immediately; all outputs at reset values.

Source files
------------

// File: rtl/debug_unlock_ctrl.sv
// -----------------------------------------------------------------------------
// debug_unlock_ctrl
//
// Purpose:
//   Gates a debug write-override grant behind a two-word key sequence.
//   A correct KEY0 then KEY1 opens a session of SESSION_CYC cycles.
//   A wrong word counts as a failure and forces a PENALTY_CYC dead time.
//   Reaching MAX_FAIL failures locks the block until reset.
//
// Handshake:
//   A key word is transferred on any rising Clk edge where
//   key_valid && key_ready. key_ready depends only on the current state, so
//   the source may hold key_valid high with no combinational loop.
//   key_data is sampled only on that transfer.
//
// Ports:
//   Clk            in   rising-edge clock
//   resetn         in   asynchronous, active-low reset
//   key_valid      in   key word offered
//   key_data[15:0] in   key word
//   key_ready      out  controller accepts a key word this cycle
//   relock         in   end the session, or abort a half-entered sequence
//   debug_unlocked out  registered grant, high exactly while UNLOCKED
//   lockout        out  registered permanent-lockout indicator
//   fail_count[1:0] out failed attempts since reset or last unlock
//   state_dbg[2:0] out  current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module debug_unlock_ctrl #(
  parameter logic [15:0] KEY0        = 16'hA5C3,
  parameter logic [15:0] KEY1        = 16'h3C5A,
  parameter int          SESSION_CYC = 1024,
  parameter int          PENALTY_CYC = 16,
  parameter int          MAX_FAIL    = 3
) (
  input  logic        Clk,
  input  logic        resetn,
  input  logic        key_valid,
  input  logic [15:0] key_data,
  output logic        key_ready,
  input  logic        relock,
  output logic        debug_unlocked,
  output logic        lockout,
  output logic [1:0]  fail_count,
  output logic [2:0]  state_dbg
);

  // Each counter is loaded with (length - 1) and counted down to 0.
  // That gives exactly `length` cycles in the state.
  localparam int SES_W = (SESSION_CYC > 1) ? $clog2(SESSION_CYC) : 1;
  localparam int PEN_W = (PENALTY_CYC > 1) ? $clog2(PENALTY_CYC) : 1;

  localparam logic [SES_W-1:0] SES_LOAD   = SES_W'(SESSION_CYC - 1);
  localparam logic [PEN_W-1:0] PEN_LOAD   = PEN_W'(PENALTY_CYC - 1);
  localparam logic [1:0]       FAIL_LIMIT = 2'(MAX_FAIL);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_K1  = 3'd1,
    ST_UNLOCKED = 3'd2,
    ST_PENALTY  = 3'd3,
    ST_LOCKOUT  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [SES_W-1:0] sess_q, sess_d;
  logic [PEN_W-1:0] pen_q, pen_d;
  logic [1:0]       fail_q, fail_d;
  logic             debug_unlocked_q;
  logic             lockout_q;

  logic             accept;
  logic             fail_event;
  logic [1:0]       fail_inc;

  // ---------------------------------------------------------------------------
  // State register.
  // The grant and lockout flags are registered from the next state.
  // They therefore track the state exactly, one edge behind nothing.
  // Reset clears them at the same instant as the state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= ST_IDLE;
      sess_q           <= '0;
      pen_q            <= '0;
      fail_q           <= 2'd0;
      debug_unlocked_q <= 1'b0;
      lockout_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      sess_q           <= sess_d;
      pen_q            <= pen_d;
      fail_q           <= fail_d;
      debug_unlocked_q <= (state_d == ST_UNLOCKED);
      lockout_q        <= (state_d == ST_LOCKOUT);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    sess_d     = sess_q;
    pen_d      = pen_q;
    fail_d     = fail_q;
    fail_event = 1'b0;
    accept     = key_valid & key_ready;

    // Saturating increment.
    // MAX_FAIL is at most 3, so the 2-bit count never wraps.
    fail_inc = (fail_q >= FAIL_LIMIT) ? fail_q : fail_q + 2'd1;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (key_data == KEY0) state_d = ST_WAIT_K1;
          else                  fail_event = 1'b1;
        end
      end

      ST_WAIT_K1: begin
        // An abort beats a key word offered in the same cycle.
        // The abort is not counted as a failure.
        if (relock) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          if (key_data == KEY1) begin
            state_d = ST_UNLOCKED;
            sess_d  = SES_LOAD;
            fail_d  = 2'd0;
          end else begin
            fail_event = 1'b1;
          end
        end
      end

      ST_UNLOCKED: begin
        if (relock || (sess_q == '0)) state_d = ST_IDLE;
        else                          sess_d  = sess_q - 1'b1;
      end

      ST_PENALTY: begin
        if (pen_q == '0) state_d = ST_IDLE;
        else             pen_d   = pen_q - 1'b1;
      end

      ST_LOCKOUT: begin
        state_d = ST_LOCKOUT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (fail_event) begin
      fail_d = fail_inc;
      if (fail_inc == FAIL_LIMIT) begin
        state_d = ST_LOCKOUT;
      end else begin
        state_d = ST_PENALTY;
        pen_d   = PEN_LOAD;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic.
  // key_ready is decoded from the current state only.
  // ---------------------------------------------------------------------------
  always_comb begin
    key_ready      = (state_q == ST_IDLE) || (state_q == ST_WAIT_K1);
    debug_unlocked = debug_unlocked_q;
    lockout        = lockout_q;
    fail_count     = fail_q;
    state_dbg      = state_q;
  end

endmodule

// File: tb/tb_debug_unlock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_debug_unlock_ctrl
//
// The driver applies inputs at the falling edge.
// A reference model predicts what is visible after the next rising edge, and
// that prediction is pushed into exp_q.
// The monitor samples the DUT just after each rising edge and checks it
// against the head of exp_q.
// Observation vector: {key_ready, debug_unlocked, lockout, fail_count[1:0]}.
// -----------------------------------------------------------------------------
module tb_debug_unlock_ctrl;

  localparam logic [15:0] KEY0        = 16'hA5C3;
  localparam logic [15:0] KEY1        = 16'h3C5A;
  localparam int          SESSION_CYC = 1024;
  localparam int          PENALTY_CYC = 16;
  localparam int          MAX_FAIL    = 3;

  // Model modes.
  localparam int M_IDLE   = 0;
  localparam int M_FIRST  = 1;
  localparam int M_OPEN   = 2;
  localparam int M_DEAD   = 3;
  localparam int M_LOCKED = 4;

  logic        Clk = 1'b0;
  logic        resetn = 1'b0;
  logic        key_valid = 1'b0;
  logic [15:0] key_data = 16'h0;
  logic        relock = 1'b0;
  logic        key_ready;
  logic        debug_unlocked;
  logic        lockout;
  logic [1:0]  fail_count;
  logic [2:0]  state_dbg;

  logic [4:0]  exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;

  // Reference model state.
  int m_mode = M_IDLE;
  int m_fails = 0;
  int m_left = 0;

  debug_unlock_ctrl #(
    .KEY0(KEY0), .KEY1(KEY1), .SESSION_CYC(SESSION_CYC),
    .PENALTY_CYC(PENALTY_CYC), .MAX_FAIL(MAX_FAIL)
  ) dut (
    .Clk(Clk), .resetn(resetn), .key_valid(key_valid), .key_data(key_data),
    .key_ready(key_ready), .relock(relock), .debug_unlocked(debug_unlocked),
    .lockout(lockout), .fail_count(fail_count), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [4:0] got,
                       input logic [4:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got(kr,du,lo,fc)=%b required=%b",
               name, cyc, got, exp);
    end
  endtask

  function automatic logic [4:0] model_obs();
    logic kr, du, lo;
    kr = (m_mode == M_IDLE) || (m_mode == M_FIRST);
    du = (m_mode == M_OPEN);
    lo = (m_mode == M_LOCKED);
    return {kr, du, lo, 2'(m_fails)};
  endfunction

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_fails = 0;
    m_left  = 0;
  endtask

  task automatic model_fail();
    m_fails = (m_fails + 1 > MAX_FAIL) ? MAX_FAIL : m_fails + 1;
    if (m_fails == MAX_FAIL) begin
      m_mode = M_LOCKED;
    end else begin
      m_mode = M_DEAD;
      m_left = PENALTY_CYC;
    end
  endtask

  // One rising edge with the given inputs.
  // m_left holds the number of whole cycles still to spend in the open or
  // dead window.
  task automatic model_edge(input logic kv, input logic [15:0] kd,
                            input logic rl);
    bit acc;
    acc = kv && ((m_mode == M_IDLE) || (m_mode == M_FIRST));
    case (m_mode)
      M_IDLE: begin
        if (acc) begin
          if (kd == KEY0) m_mode = M_FIRST;
          else            model_fail();
        end
      end
      M_FIRST: begin
        if (rl) begin
          m_mode = M_IDLE;
        end else if (acc) begin
          if (kd == KEY1) begin
            m_mode  = M_OPEN;
            m_left  = SESSION_CYC;
            m_fails = 0;
          end else begin
            model_fail();
          end
        end
      end
      M_OPEN: begin
        m_left--;
        if (rl || m_left == 0) m_mode = M_IDLE;
      end
      M_DEAD: begin
        m_left--;
        if (m_left == 0) m_mode = M_IDLE;
      end
      default: ;
    endcase
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic kv, input logic [15:0] kd, input logic rl);
    key_valid = kv;
    key_data  = kd;
    relock    = rl;
    model_edge(kv, kd, rl);
    exp_q.push_back(model_obs());
    @(negedge Clk);
  endtask

  task automatic rand_step();
    int pick;
    logic [15:0] kd;
    pick = $urandom_range(0, 3);
    kd = (pick == 0) ? KEY0 : (pick == 1) ? KEY1 : 16'($urandom);
    step(1'($urandom_range(0, 1)), kd, ($urandom_range(0, 15) == 0));
  endtask

  // Asserts reset between clock edges and checks the outputs immediately.
  task automatic mid_reset();
    check("pre_reset_grant", {4'b0, debug_unlocked}, {4'b0, m_mode == M_OPEN});
    key_valid = 1'b0;
    relock    = 1'b0;
    resetn    = 1'b0;
    #1;
    check("async_reset", {key_ready, debug_unlocked, lockout, fail_count},
          5'b10000);
    model_reset();
    exp_q.push_back(model_obs());
    @(negedge Clk);
    resetn = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always begin
    @(posedge Clk);
    #1;
    if (mon_en) begin
      cyc++;
      if (exp_q.size() > 0)
        check("obs", {key_ready, debug_unlocked, lockout, fail_count},
              exp_q.pop_front());
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    #1;
    check("reset_hold", {key_ready, debug_unlocked, lockout, fail_count},
          5'b10000);
    repeat (3) @(negedge Clk);
    check("reset_state", {key_ready, debug_unlocked, lockout, fail_count},
          5'b10000);
    resetn = 1'b1;
    mon_en = 1'b1;

    // Full session on consecutive key words.
    // Key inputs are ignored while open.
    step(1'b1, KEY0, 1'b0);
    step(1'b1, KEY1, 1'b0);
    repeat (SESSION_CYC) step(1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
    repeat (2) step(1'b0, 16'h0, 1'b0);

    // Relock during the session.
    step(1'b1, KEY0, 1'b0);
    step(1'b1, KEY1, 1'b0);
    repeat (9) step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    repeat (2) step(1'b0, 16'h0, 1'b0);

    // Single wrong word.
    // Offers during the dead time are ignored.
    step(1'b1, 16'h1234, 1'b0);
    repeat (PENALTY_CYC) step(1'b1, KEY0, 1'($urandom_range(0, 1)));
    repeat (2) step(1'b0, 16'h0, 1'b0);
    mid_reset();

    // Three failures lead to lockout.
    // A correct sequence afterwards grants nothing.
    step(1'b1, KEY0, 1'b0);
    step(1'b1, 16'h0000, 1'b0);
    repeat (PENALTY_CYC) step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h1111, 1'b0);
    repeat (PENALTY_CYC) step(1'b0, 16'h0, 1'b0);
    step(1'b1, KEY0, 1'b0);
    step(1'b1, 16'hFFFF, 1'b0);
    step(1'b1, KEY0, 1'b0);
    step(1'b1, KEY1, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    repeat (4) step(1'b0, 16'h0, 1'b0);
    mid_reset();

    // Abort beats a same-cycle KEY1.
    step(1'b1, KEY0, 1'b0);
    step(1'b1, KEY1, 1'b1);
    repeat (3) step(1'b0, 16'h0, 1'b0);

    // Reset while granted.
    step(1'b1, KEY0, 1'b0);
    step(1'b1, KEY1, 1'b0);
    repeat (5) step(1'b0, 16'h0, 1'b0);
    mid_reset();

    // Random traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) mid_reset();
      else                             rand_step();
    end

    @(posedge Clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
